stack_engine: RTL
=================

// Module: stack_engine
// PURPOSE
//   Responder side of the control FSM's stack push/pop commands. Owns one
//   hardware stack: the pointer register plus a synchronous-read RAM.
//   Serves one command at a time over a valid/ready request channel and
//   returns a single-cycle response pulse. Instantiated once for the main
//   stack and once for the return stack.
// PARAMETERS
//   DATA_W  16  width of a stack entry
//   DEPTH   64  number of entries; must equal 2**ADDR_W
//   ADDR_W  6   RAM address width
// PORTS
//   clk        in   1         clock, rising edge
//   rst        in   1         reset, synchronous, active-high
//   cmd_valid  in   1         command present
//   cmd_ready  out  1         engine accepts a command this cycle
//   cmd_op     in   2         00 push, 01 pop, 10 peek, 11 clear
//   cmd_data   in   DATA_W    push operand; ignored for other ops
//   rsp_valid  out  1         one-cycle response pulse, no back-pressure
//   rsp_data   out  DATA_W    pop/peek result; 0 for push, clear and errors
//   rsp_err    out  1         qualifies rsp_valid: overflow or underflow
//   count      out  ADDR_W+1  current number of entries (0..DEPTH)
//   full       out  1         count == DEPTH
//   empty      out  1         count == 0
// BEHAVIOUR
//   - Reset values (cycle after rst high):
//     - state IDLE; count=0; full=0; empty=1.
//     - rsp_valid=0, rsp_err=0, rsp_data=0.
//     - cmd_ready=0 while rst high, 1 on the first cycle after.
//     - RAM contents are not cleared.
//   - FSM states: IDLE, RD, ACK.
//     - cmd_ready = (state==IDLE) && !rst.
//     - Accept occurs when cmd_valid && cmd_ready (cycle T).
//   - push, accepted at T:
//     - If !full: mem[count] <= cmd_data and count++ at edge T.
//     - IDLE->ACK; at T+1 rsp_valid=1, rsp_err=0, rsp_data=0.
//     - If full: no write, count unchanged; at T+1 rsp_err=1.
//   - pop, accepted at T:
//     - If !empty: RAM read addr = count-1, count-- at edge T.
//     - IDLE->RD->ACK; at T+2 rsp_valid=1, rsp_data = entry read.
//     - If empty: count unchanged, same latency, rsp_data=0, rsp_err=1.
//   - peek: identical to pop but count is never changed.
//   - clear: count<=0 at edge T; IDLE->ACK; ack at T+1, rsp_err=0.
//   - ACK->IDLE unconditionally, so cmd_ready is high again at T+2 (push or
//     clear) or T+3 (pop or peek). The channel never pipelines two commands.
//   - rsp_valid is high only in ACK. rsp_data and rsp_err are registered and
//     return to 0 the cycle after ACK.
//   - Derived flags:
//     - count wraps neither way: saturation is enforced by the error rules.
//     - full and empty are combinational from count.
//   - cmd_valid while !cmd_ready: ignored; requester must hold or reissue.
//   - rst mid-operation (state RD or ACK):
//     - Return to IDLE; any pending response is dropped (no rsp_valid).
//     - count=0.
//   - Address arithmetic is ADDR_W bits. count-1 is computed only when
//     count>0; count==DEPTH never addresses RAM on push.
// TESTING
//   1 rst 2 cycles -> count=0, empty=1, full=0, rsp_valid=0; cmd_ready=1 next
//     cycle.
//   2 push 0x1111, 0x2222, 0x3333 then pop x3
//     -> rsp_data 0x3333, 0x2222, 0x1111, each at T+2.
//     -> count 3->0; empty=1 at end.
//   3 DEPTH=4: push 5 values
//     -> 5th ack has rsp_err=1; count stays 4; full=1.
//     -> a following pop returns the 4th value.
//   4 pop on empty -> rsp_valid at T+2, rsp_err=1, rsp_data=0, count=0.
//   5 push 0xABCD, peek x2 -> both return 0xABCD, count stays 1; clear ->
//     count=0, ack at T+1.
//   6 push 0x0042, issue pop, assert rst at T+1
//     -> no rsp_valid; count=0; cmd_ready=1 one cycle after rst drops.

Source files
------------

// File: rtl/stack_engine.sv
// Hardware stack responder: pointer register plus synchronous-read RAM, serving
// push/pop/peek/clear one at a time with a single-cycle response pulse.
//
// state | meaning
// IDLE  | ready for a command
// RD    | pop/peek waiting on the synchronous RAM read
// ACK   | response pulse on rsp_valid
module stack_engine #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty
);

    localparam logic [1:0] OP_PUSH  = 2'b00;
    localparam logic [1:0] OP_POP   = 2'b01;
    localparam logic [1:0] OP_PEEK  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_W:0]   CNT_FULL = DEPTH[ADDR_W:0];

    typedef enum logic [1:0] {
        IDLE,
        RD,
        ACK
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_q;
    logic              pend_err;
    logic              accept;
    logic              is_read_op;
    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] top_addr;

    assign full       = (count == CNT_FULL);
    assign empty      = (count == '0);
    assign cmd_ready  = (state == IDLE) && !rst;
    assign accept     = cmd_valid && cmd_ready;
    assign is_read_op = (cmd_op == OP_POP) || (cmd_op == OP_PEEK);

    // Only the low ADDR_W bits address the RAM; a full stack never writes,
    // and top_addr is only used when the stack is non-empty.
    assign wr_addr  = count[ADDR_W-1:0];
    assign top_addr = count[ADDR_W-1:0] - ADDR_ONE;
    assign wr_en    = accept && (cmd_op == OP_PUSH) && !full;
    assign rd_en    = accept && is_read_op && !empty;

    // RAM contents survive reset, so this block has no reset branch.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= cmd_data;
        end
        if (rd_en) begin
            rd_q <= mem[top_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            pend_err  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_data  <= '0;
                    if (accept) begin
                        case (cmd_op)
                            OP_PUSH: begin
                                if (!full) begin
                                    count <= count + CNT_ONE;
                                end
                                rsp_valid <= 1'b1;
                                rsp_err   <= full;
                                state     <= ACK;
                            end
                            OP_POP: begin
                                if (!empty) begin
                                    count <= count - CNT_ONE;
                                end
                                pend_err <= empty;
                                state    <= RD;
                            end
                            OP_PEEK: begin
                                pend_err <= empty;
                                state    <= RD;
                            end
                            OP_CLEAR: begin
                                count     <= '0;
                                rsp_valid <= 1'b1;
                                rsp_err   <= 1'b0;
                                state     <= ACK;
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
                RD: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= pend_err;
                    rsp_data  <= pend_err ? '0 : rd_q;
                    state     <= ACK;
                end
                ACK: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_data  <= '0;
                    state     <= IDLE;
                end
                default: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_data  <= '0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
